// File: rtl/add32_pkg.sv
// Shared sizing constants and types for the add32 datapath adder.
package add32_pkg;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned BLOCK = 4;
  localparam int unsigned NBLK  = WIDTH / BLOCK;

  typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/add32_if.sv
// Operand/result bundle for add32: operands in, registered sum and flags out.
interface add32_if #(parameter int unsigned WIDTH = add32_pkg::WIDTH);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (output a, b, input z, cout, ovf, zero);
  modport slave  (input a, b, output z, cout, ovf, zero);
endinterface

// File: rtl/add32_cla4.sv
// 4-bit carry-lookahead block: local sum plus group generate/propagate.
module cla4
  import add32_pkg::*;
(
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             G,
  output logic             P
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries are fully expanded so nothing ripples inside the block.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;
endmodule

// File: rtl/add32.sv
// Two-level carry-lookahead adder with registered sum, carry, overflow and zero flags.
module add32 #(
  parameter int unsigned WIDTH = add32_pkg::WIDTH
) (
  input  logic   clk,
  input  logic   rst_n,
  add32_if.slave bus
);
  import add32_pkg::*;

  localparam int unsigned NB = WIDTH / BLOCK;

  logic [WIDTH-1:0] sum;
  logic [NB-1:0]    grp_g;
  logic [NB-1:0]    grp_p;
  logic [NB:0]      blk_c;
  logic             term;

  logic [WIDTH-1:0] z_d, z_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;
  logic             c_msb;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    cla4 u_cla4 (
      .a   (bus.a[k*BLOCK +: BLOCK]),
      .b   (bus.b[k*BLOCK +: BLOCK]),
      .cin (blk_c[k]),
      .s   (sum[k*BLOCK +: BLOCK]),
      .G   (grp_g[k]),
      .P   (grp_p[k])
    );
  end

  // Each block carry-in is a flat sum-of-products over lower groups, not a G/P ripple.
  always_comb begin
    blk_c = '0;
    term  = 1'b0;
    for (int unsigned k = 1; k <= NB; k++) begin
      for (int unsigned j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int unsigned m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        blk_c[k] = blk_c[k] | term;
      end
    end
  end

  // Carry into the MSB recovered from its propagate and sum bits.
  assign c_msb  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1] ^ sum[WIDTH-1];
  assign z_d    = sum;
  assign cout_d = blk_c[NB];
  assign ovf_d  = c_msb ^ blk_c[NB];
  assign zero_d = ~|sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      z_q    <= z_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.z    = z_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_add32.sv
// Randomized bench for add32 against a plain-arithmetic reference, plus literal checks.
module tb_add32;
  import add32_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  add32_if #(.WIDTH(32)) bus ();

  add32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        chk_en = 1'b0;

  // Reference: exact 33-bit sum, flags from the arithmetic definitions.
  logic [32:0] m_sum;
  logic        m_ovf_now;
  word_t       m_z;
  logic        m_c, m_o, m_zero;

  assign m_sum     = {1'b0, bus.a} + {1'b0, bus.b};
  assign m_ovf_now = (bus.a[31] == bus.b[31]) && (m_sum[31] != bus.a[31]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_z    <= 32'd0;
      m_c    <= 1'b0;
      m_o    <= 1'b0;
      m_zero <= 1'b1;
    end else begin
      m_z    <= m_sum[31:0];
      m_c    <= m_sum[32];
      m_o    <= m_ovf_now;
      m_zero <= (m_sum[31:0] == 32'd0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({bus.z, bus.cout, bus.ovf, bus.zero} !== {m_z, m_c, m_o, m_zero}) begin
        n_bad++;
        $display("FAIL model t=%0t: got z=%h cout=%b ovf=%b zero=%b, want z=%h cout=%b ovf=%b zero=%b",
                 $time, bus.z, bus.cout, bus.ovf, bus.zero, m_z, m_c, m_o, m_zero);
      end
    end
  end

  function automatic logic [34:0] pk(input logic [31:0] z, input logic c, input logic o,
                                     input logic zr);
    return {z, c, o, zr};
  endfunction

  task automatic check(input string name, input logic [34:0] exp);
    logic [34:0] got;
    got = {bus.z, bus.cout, bus.ovf, bus.zero};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got z=%h cout=%b ovf=%b zero=%b, want z=%h cout=%b ovf=%b zero=%b",
               name, got[34:3], got[2], got[1], got[0], exp[34:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    bus.a = a;
    bus.b = b;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.a = 32'd5;
    bus.b = 32'd7;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_hold", pk(32'd0, 1'b0, 1'b0, 1'b1));
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", pk(32'd12, 1'b0, 1'b0, 1'b0));

    apply(32'd1, 32'h0000_000A);
    check("basic", pk(32'd11, 1'b0, 1'b0, 1'b0));

    bus.a = 32'd1;
    bus.b = 32'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("accum%0d", i), pk(32'd11 + 32'(i), 1'b0, 1'b0, 1'b0));
      bus.b = bus.z;
    end
    check("accum_final", pk(32'd15, 1'b0, 1'b0, 1'b0));

    apply(32'hFFFF_FFFF, 32'h0000_0001);
    check("unsigned_wrap", pk(32'd0, 1'b1, 1'b0, 1'b1));
    apply(32'h7FFF_FFFF, 32'h0000_0001);
    check("ovf_pos", pk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    apply(32'h8000_0000, 32'h8000_0000);
    check("ovf_neg", pk(32'd0, 1'b1, 1'b1, 1'b1));
    apply(32'h0FFF_FFFF, 32'h0000_0001);
    check("carry_chain", pk(32'h1000_0000, 1'b0, 1'b0, 1'b0));
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("all_ones", pk(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0));

    bus.a = 32'd3;
    bus.b = 32'd4;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", pk(32'd0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset", pk(32'd7, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = ~ra + 32'd1;
        1: rb = ~ra;
        2: ra = {1'b0, ra[30:0]};
        3: begin ra = 32'h8000_0000 | ra; rb = 32'h8000_0000 | rb; end
        default: ;
      endcase
      bus.a = ra;
      bus.b = rb;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/add32.md
# add32

32-bit two's-complement/unsigned adder with a registered result, used as the datapath adder of the register-file exercise. It sums two 32-bit operands and presents the sum one clock later, along with carry, overflow and zero flags. The adder core is a two-level carry-lookahead tree built from 4-bit lookahead blocks. It is intended to feed results back into a register file for iterative accumulation.

## Interface

Parameters:
- WIDTH, 32: operand/result width; must be a multiple of 4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- z  output  WIDTH  registered sum a + b, modulo 2^WIDTH.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- cout  output  1  registered carry out of the MSB (unsigned overflow).
- ovf  output  1  registered signed overflow: a[MSB]==b[MSB] and z[MSB]!=a[MSB].
- zero  output  1  registered flag, 1 when the registered sum is 0.

## Operation

- Combinational core computes sum = a + b with carry-in fixed at 0.
- Per bit: generate g = a&b, propagate p = a^b.
- 4-bit blocks produce a 4-bit sum, group generate G and group propagate P.
- A second-level lookahead unit computes block carry-ins from the group G/P signals.
- Sum bit i = p[i] ^ c[i].
- cout = carry out of bit WIDTH-1.
- ovf = c[WIDTH-1] ^ c[WIDTH].
- zero = (sum == 0), evaluated on the combinational sum and registered together with it.
- All outputs are registered together; no partially updated output state is ever visible.
- Arithmetic wraps: 0xFFFFFFFF + 0x00000001 gives z=0, cout=1, zero=1, ovf=0.
- No enable input: the output registers capture every cycle.

## Timing

- Latency: exactly 1 cycle. Operands present before rising edge N appear on z/cout/ovf/zero after edge N.
- Throughput: one addition per cycle.
- Reset: when rst_n=0, z=0, cout=0, ovf=0, zero=1, immediately and independently of clk.
- Release of rst_n takes effect at the first rising edge where rst_n=1; that edge captures the current a+b.
- Reset asserted mid-stream clears the outputs at once; any in-flight result is discarded.
- Feedback (z wired back to b) is legal. With a held constant, z advances by a on every cycle.
- Critical path: bit p/g, then group G/P, then lookahead, then sum XOR, then register. No ripple through more than 4 bits.

## Structure

- Package add32_pkg holds:
  - WIDTH default (32) and BLOCK = 4;
  - NBLK = WIDTH/BLOCK;
  - a typedef for the WIDTH-bit word.
- Sub-module cla4: inputs a[3:0], b[3:0], cin; outputs s[3:0], G, P.
- Top-level add32 instantiates NBLK cla4 instances via generate, plus an inline second-level lookahead (carry per block from G/P chain) and the output register process.

## Test plan

- Reset: hold rst_n=0 with a=5, b=7 and toggle clk. Required: z=0, zero=1, cout=0, ovf=0. Release reset; after the next edge z=12, zero=0.
- Basic sum: a=1, b=0x0000000A. After one edge z=11 (0x0B), cout=0, ovf=0.
- Accumulate with feedback: a=1, b=z, starting from b=10. Successive cycles give z=11, 12, 13, …; after 5 edges z=15.
- Unsigned wrap: a=0xFFFFFFFF, b=1. Required: z=0, cout=1, zero=1, ovf=0.
- Signed overflow:
  - a=0x7FFFFFFF, b=1 gives z=0x80000000, ovf=1, cout=0;
  - a=0x80000000, b=0x80000000 gives z=0, ovf=1, cout=1.
- Carry propagation across all blocks: a=0x0FFFFFFF, b=0x00000001 gives z=0x10000000. Also, a random-operand sweep of 10000 vectors must match the a+b reference, including the flags, at 1-cycle latency.
